// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode helpers for the sequential ALU.
// Opcode 20 (MUL) is only implemented when MUL_EN is defined.
package alu_pkg;

    localparam logic [4:0] OP_ADD           = 5'd0;
    localparam logic [4:0] OP_CADD          = 5'd1;
    localparam logic [4:0] OP_SUB           = 5'd2;
    localparam logic [4:0] OP_BSUB          = 5'd3;
    localparam logic [4:0] OP_NEG           = 5'd4;
    localparam logic [4:0] OP_INC           = 5'd5;
    localparam logic [4:0] OP_DEC           = 5'd6;
    localparam logic [4:0] OP_AND           = 5'd7;
    localparam logic [4:0] OP_OR            = 5'd8;
    localparam logic [4:0] OP_XOR           = 5'd9;
    localparam logic [4:0] OP_NOT           = 5'd10;
    localparam logic [4:0] OP_NOR           = 5'd11;
    localparam logic [4:0] OP_L_LOG_SHIFT   = 5'd12;
    localparam logic [4:0] OP_R_LOG_SHIFT   = 5'd13;
    localparam logic [4:0] OP_L_ARITH_SHIFT = 5'd14;
    localparam logic [4:0] OP_R_ARITH_SHIFT = 5'd15;
    localparam logic [4:0] OP_L_ROT         = 5'd16;
    localparam logic [4:0] OP_R_ROT         = 5'd17;
    localparam logic [4:0] OP_L_CROT        = 5'd18;
    localparam logic [4:0] OP_R_CROT        = 5'd19;
    localparam logic [4:0] OP_MUL           = 5'd20;

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op >= OP_L_LOG_SHIFT) && (op <= OP_R_CROT);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter/rotator; with MUL_EN also a radix-2 Booth multiplier.
// The first step is taken in the accept cycle, so an n-step operation finishes n edges later.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] work_q, work_d, src_work, s_work;
    logic             carry_q, carry_d, src_carry, s_carry;
    logic             ovf_q, ovf_d, src_ovf, s_ovf;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_cur;
    logic [4:0]       op_q, op_d, op_cur;
    logic             step_en;

`ifdef MUL_EN
    logic [WIDTH:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH:0] src_acc, src_mcand, booth_sum, s_acc;
    logic           q1_q, q1_d, src_q1, s_q1;
`else
    logic unused_b;
    assign unused_b = ^b[WIDTH-1:SHW];
`endif

    always_comb begin
        step_en   = start | run;
        op_cur    = start ? op : op_q;
        src_work  = start ? a : work_q;
        src_carry = start ? carry_in : carry_q;
        src_ovf   = start ? 1'b0 : ovf_q;
        cnt_cur   = start ? CW'(b[SHW-1:0]) : cnt_q;
`ifdef MUL_EN
        src_acc   = start ? '0 : acc_q;
        src_mcand = start ? {a[WIDTH-1], a} : mcand_q;
        src_q1    = start ? 1'b0 : q1_q;
        // Multiplier B lives in the working register and drains out as the product low half
        if (start && (op == OP_MUL)) begin
            cnt_cur  = CW'(WIDTH);
            src_work = b;
        end
        booth_sum = src_acc;
        s_acc     = src_acc;
        s_q1      = src_q1;
`endif
        s_work  = src_work;
        s_carry = src_carry;
        s_ovf   = src_ovf;
        case (op_cur)
            OP_L_LOG_SHIFT: begin
                s_work  = {src_work[WIDTH-2:0], 1'b0};
                s_carry = src_work[WIDTH-1];
            end
            OP_R_LOG_SHIFT: begin
                s_work  = {1'b0, src_work[WIDTH-1:1]};
                s_carry = src_work[0];
            end
            OP_L_ARITH_SHIFT: begin
                s_work  = {src_work[WIDTH-2:0], 1'b0};
                s_carry = src_work[WIDTH-1];
                s_ovf   = src_ovf | (src_work[WIDTH-1] ^ src_work[WIDTH-2]);
            end
            OP_R_ARITH_SHIFT: begin
                s_work  = {src_work[WIDTH-1], src_work[WIDTH-1:1]};
                s_carry = src_work[0];
            end
            OP_L_ROT: begin
                s_work  = {src_work[WIDTH-2:0], src_work[WIDTH-1]};
                s_carry = src_work[WIDTH-1];
            end
            OP_R_ROT: begin
                s_work  = {src_work[0], src_work[WIDTH-1:1]};
                s_carry = src_work[0];
            end
            OP_L_CROT: begin
                s_work  = {src_work[WIDTH-2:0], src_carry};
                s_carry = src_work[WIDTH-1];
            end
            OP_R_CROT: begin
                s_work  = {src_carry, src_work[WIDTH-1:1]};
                s_carry = src_work[0];
            end
`ifdef MUL_EN
            OP_MUL: begin
                case ({src_work[0], src_q1})
                    2'b01:   booth_sum = src_acc + src_mcand;
                    2'b10:   booth_sum = src_acc - src_mcand;
                    default: booth_sum = src_acc;
                endcase
                s_acc   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                s_work  = {booth_sum[0], src_work[WIDTH-1:1]};
                s_q1    = src_work[0];
                s_carry = 1'b0;
                // Product fits only if the upper half is a pure sign extension of the lower
                s_ovf   = (s_acc != {(WIDTH + 1){s_work[WIDTH-1]}});
            end
`endif
            default: ;
        endcase

        done = step_en && (cnt_cur == CW'(1));
        res  = s_work;
        cout = s_carry;
        ovf  = s_ovf;

        work_d  = step_en ? s_work : work_q;
        carry_d = step_en ? s_carry : carry_q;
        ovf_d   = step_en ? s_ovf : ovf_q;
        cnt_d   = step_en ? (cnt_cur - CW'(1)) : cnt_q;
        op_d    = op_cur;
`ifdef MUL_EN
        acc_d   = step_en ? s_acc : acc_q;
        q1_d    = step_en ? s_q1 : q1_q;
        mcand_d = src_mcand;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
`ifdef MUL_EN
            acc_q   <= '0;
            q1_q    <= 1'b0;
            mcand_q <= '0;
`endif
        end else begin
            work_q  <= work_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`ifdef MUL_EN
            acc_q   <= acc_d;
            q1_q    <= q1_d;
            mcand_q <= mcand_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Parametrised sequential ALU with valid/ready handshakes and an iterative shifter.
// Define MUL_EN to add a signed Booth multiplier on opcode 20.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;

    logic             su_start, su_run, su_done, su_cout, su_ovf;
    logic [WIDTH-1:0] su_res;
    logic             is_mul, is_iter;

    logic [WIDTH-1:0] ax, ay, logic_res;
    logic [WIDTH:0]   arith_r;
    logic             acin, do_sub, is_arith, arith_v;

`ifdef MUL_EN
    assign is_mul = (opcode == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif
    assign is_iter  = is_shift_op(opcode) | is_mul;
    // A zero shift amount bypasses the shifter; MUL always iterates
    assign su_start = (state_q == StIdle) && in_valid && is_iter &&
                      (is_mul || (operand_b[SHW-1:0] != '0));
    assign su_run   = (state_q == StShift);

    alu_shift_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (su_start),
        .run      (su_run),
        .op       (opcode),
        .a        (operand_a),
        .b        (operand_b),
        .carry_in (carry_in),
        .done     (su_done),
        .res      (su_res),
        .cout     (su_cout),
        .ovf      (su_ovf)
    );

    always_comb begin
        ax        = operand_a;
        ay        = operand_b;
        acin      = 1'b0;
        do_sub    = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (opcode)
            OP_ADD:  ;
            OP_CADD: acin = carry_in;
            OP_INC:  ay = WIDTH'(1);
            OP_SUB:  do_sub = 1'b1;
            OP_BSUB: begin
                do_sub = 1'b1;
                acin   = carry_in;
            end
            OP_DEC: begin
                do_sub = 1'b1;
                ay     = WIDTH'(1);
            end
            OP_NEG: begin
                do_sub = 1'b1;
                ax     = '0;
                ay     = operand_a;
            end
            OP_AND: begin
                is_arith  = 1'b0;
                logic_res = operand_a & operand_b;
            end
            OP_OR: begin
                is_arith  = 1'b0;
                logic_res = operand_a | operand_b;
            end
            OP_XOR: begin
                is_arith  = 1'b0;
                logic_res = operand_a ^ operand_b;
            end
            OP_NOT: begin
                is_arith  = 1'b0;
                logic_res = ~operand_a;
            end
            OP_NOR: begin
                is_arith  = 1'b0;
                logic_res = ~(operand_a | operand_b);
            end
            default: is_arith = 1'b0;
        endcase
        // Bit WIDTH of a subtraction is the borrow, of an addition the carry
        if (do_sub) begin
            arith_r = {1'b0, ax} - {1'b0, ay} - {{WIDTH{1'b0}}, acin};
            arith_v = (ax[WIDTH-1] != ay[WIDTH-1]) && (arith_r[WIDTH-1] != ax[WIDTH-1]);
        end else begin
            arith_r = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
            arith_v = (ax[WIDTH-1] == ay[WIDTH-1]) && (arith_r[WIDTH-1] != ax[WIDTH-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (su_start) begin
                        if (su_done) begin
                            result_d = su_res;
                            carry_d  = su_cout;
                            ovf_d    = su_ovf;
                            state_d  = StHold;
                        end else begin
                            state_d = StShift;
                        end
                    end else if (is_iter) begin
                        result_d = operand_a;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        state_d  = StHold;
                    end else begin
                        result_d = is_arith ? arith_r[WIDTH-1:0] : logic_res;
                        carry_d  = is_arith & arith_r[WIDTH];
                        ovf_d    = is_arith & arith_v;
                        state_d  = StHold;
                    end
                end
            end
            StShift: begin
                if (su_done) begin
                    result_d = su_res;
                    carry_d  = su_cout;
                    ovf_d    = su_ovf;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StHold);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = (result_q == '0);
    assign negative  = result_q[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; opcode 20 is checked as MUL when MUL_EN is defined.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [4:0]       opcode;
    logic [WIDTH-1:0] operand_a, operand_b, result;
    logic             carry_in, carry_out, overflow, zero, negative, busy;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic cin);
        exp_t       e;
        int         u, s, x, y, sx, sy, c, n;
        logic [7:0] w;
        logic [8:0] ring;
        logic       cr;
        e.res = '0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.lat = 1;
        case (op)
            OP_ADD, OP_CADD, OP_INC: begin
                y  = (op == OP_INC) ? 1 : int'(b);
                sy = (op == OP_INC) ? 1 : int'($signed(b));
                c  = (op == OP_CADD) ? int'(cin) : 0;
                u  = int'(a) + y + c;
                s  = int'($signed(a)) + sy + c;
                e.res = u[7:0];
                e.c   = (u > 255);
                e.v   = (s > 127) || (s < -128);
            end
            OP_SUB, OP_BSUB, OP_DEC, OP_NEG: begin
                x  = (op == OP_NEG) ? 0 : int'(a);
                sx = (op == OP_NEG) ? 0 : int'($signed(a));
                y  = (op == OP_NEG) ? int'(a) : ((op == OP_DEC) ? 1 : int'(b));
                sy = (op == OP_NEG) ? int'($signed(a)) :
                     ((op == OP_DEC) ? 1 : int'($signed(b)));
                c  = (op == OP_BSUB) ? int'(cin) : 0;
                u  = x - y - c;
                s  = sx - sy - c;
                e.res = u[7:0];
                e.c   = (u < 0);
                e.v   = (s > 127) || (s < -128);
            end
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_NOT: e.res = ~a;
            OP_NOR: e.res = ~(a | b);
            OP_L_LOG_SHIFT, OP_R_LOG_SHIFT, OP_L_ARITH_SHIFT, OP_R_ARITH_SHIFT,
            OP_L_ROT, OP_R_ROT, OP_L_CROT, OP_R_CROT: begin
                n  = int'(b[2:0]);
                w  = a;
                cr = cin;
                for (int i = 0; i < n; i++) begin
                    ring = {cr, w};
                    case (op)
                        OP_L_LOG_SHIFT:   begin cr = w[7]; w = w << 1; end
                        OP_R_LOG_SHIFT:   begin cr = w[0]; w = w >> 1; end
                        OP_L_ARITH_SHIFT: begin
                            cr = w[7];
                            w  = w << 1;
                            if (w[7] != ring[7]) e.v = 1'b1;
                        end
                        OP_R_ARITH_SHIFT: begin cr = w[0]; w = {w[7], w[7:1]}; end
                        OP_L_ROT:         begin cr = w[7]; w = {w[6:0], w[7]}; end
                        OP_R_ROT:         begin cr = w[0]; w = {w[0], w[7:1]}; end
                        OP_L_CROT:        {cr, w} = {ring[7:0], ring[8]};
                        default:          {cr, w} = {ring[0], ring[8:1]};
                    endcase
                end
                e.res = w;
                e.c   = (n == 0) ? 1'b0 : cr;
                e.lat = (n == 0) ? 1 : n;
            end
`ifdef MUL_EN
            OP_MUL: begin
                s     = int'($signed(a)) * int'($signed(b));
                e.res = s[7:0];
                e.v   = (s > 127) || (s < -128);
                e.lat = 8;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic collect(input string name, input int lat);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({name, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({name, ".out_valid"}, 32'(out_valid), 32'd1);
        check_eq({name, ".latency"}, 32'(lat), 32'(e.lat));
        check_eq({name, ".result"}, 32'(result), 32'(e.res));
        check_eq({name, ".carry"}, 32'(carry_out), 32'(e.c));
        check_eq({name, ".overflow"}, 32'(overflow), 32'(e.v));
        check_eq({name, ".zero"}, 32'(zero), 32'(e.res == 8'd0));
        check_eq({name, ".negative"}, 32'(negative), 32'(e.res[7]));
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        opcode    = op;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        in_valid  = 1'b1;
        sb_q.push_back(model(op, a, b, cin));
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check_eq({name, ".in_ready_timeout"}, 32'(in_ready), 32'd1);
        drive(op, a, b, cin);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check_eq({name, ".busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        check_eq({name, ".busy_hold"}, 32'(busy), 32'd1);
        collect(name, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({name, ".valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        operand_a = '0;
        operand_b = '0;
        carry_in  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.result", 32'(result), 32'd0);
        check_eq("rst.zero", 32'(zero), 32'd1);
        check_eq("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add",    OP_ADD,           8'd100, 8'd50, 1'b0);
        run_op("sub",    OP_SUB,           8'd5,   8'd10, 1'b0);
        run_op("bsub",   OP_BSUB,          8'd0,   8'd0,  1'b1);
        run_op("rasr",   OP_R_ARITH_SHIFT, 8'h80,  8'd3,  1'b0);
        run_op("lcrot",  OP_L_CROT,        8'h81,  8'd1,  1'b0);
        run_op("inc",    OP_INC,           8'h7F,  8'd0,  1'b0);
        run_op("dec",    OP_DEC,           8'h80,  8'd0,  1'b0);
        run_op("neg",    OP_NEG,           8'h80,  8'd0,  1'b0);
        run_op("cadd",   OP_CADD,          8'hFF,  8'h00, 1'b1);
        run_op("lasl",   OP_L_ARITH_SHIFT, 8'h40,  8'd2,  1'b0);
        run_op("rcrot",  OP_R_CROT,        8'h01,  8'd7,  1'b1);
        run_op("shift0", OP_L_LOG_SHIFT,   8'h33,  8'h08, 1'b1);
        run_op("rrot",   OP_R_ROT,         8'h96,  8'd5,  1'b0);
        run_op("nor",    OP_NOR,           8'h0F,  8'h30, 1'b0);
        run_op("op20",   5'd20,            8'd12,  8'hF5, 1'b0);
        run_op("undef",  5'd27,            8'h55,  8'hAA, 1'b1);

        // Backpressure: a second request waits behind an unconsumed result
        drive(OP_ADD, 8'd100, 8'd50, 1'b0);
        @(negedge clk);
        check_eq("bp.first_valid", 32'(out_valid), 32'd1);
        drive(OP_SUB, 8'd5, 8'd10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp.in_ready", 32'(in_ready), 32'd0);
            check_eq("bp.result_stable", 32'(result), 32'(sb_q[0].res));
        end
        collect("bp.first", 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp.valid_drop", 32'(out_valid), 32'd0);
        check_eq("bp.ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        collect("bp.second", 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset two steps into a six-step shift
        opcode    = OP_L_LOG_SHIFT;
        operand_a = 8'h5A;
        operand_b = 8'd6;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("arst.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.busy", 32'(busy), 32'd0);
        check_eq("arst.in_ready", 32'(in_ready), 32'd1);
        check_eq("arst.out_valid", 32'(out_valid), 32'd0);
        check_eq("arst.result", 32'(result), 32'd0);
        check_eq("arst.carry", 32'(carry_out), 32'd0);
        check_eq("arst.overflow", 32'(overflow), 32'd0);
        check_eq("arst.zero", 32'(zero), 32'd1);
        check_eq("arst.negative", 32'(negative), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", OP_L_LOG_SHIFT, 8'h5A, 8'd6, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_op("rnd", 5'($urandom_range(0, 23)), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 8-bit ALU. It supports any data width and uses a valid/ready handshake on both input and output.
- Multi-bit shifts and rotates run as a multi-cycle iterative shifter, one bit position per cycle.
- Flags are computed with correct two's-complement rules.
- Sits between the instruction sequencer and the register file; one operation is in flight at a time.

Parameters:
- WIDTH, 8, datapath width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (state IDLE).
- opcode  in  5  operation select; encoding in package.
- operand_a  in  WIDTH  signed operand A.
- operand_b  in  WIDTH  signed operand B. Bits [SHW-1:0] are the shift/rotate amount.
- carry_in  in  1  carry for CADD, L_CROT and R_CROT; borrow for BSUB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- carry_out  out  1  carry (ADD/CADD/INC), borrow (SUB/BSUB/DEC/NEG), or last bit shifted out (shifts/rotates); 0 for logic ops.
- overflow  out  1  signed overflow: ADD/CADD/SUB/BSUB/NEG/INC/DEC, and L_ARITH_SHIFT sign change. 0 otherwise.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1.
  - out_valid=0, result=0, carry_out=0, overflow=0.
  - zero=1, negative=0 (both derived from result).
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - On in_valid & in_ready, latch opcode, operands and carry_in.
  - Non-shift ops: compute in that cycle, register result and flags, go to HOLD. out_valid rises the next cycle (latency 1).
  - Shift/rotate ops (12-19) with amount n>0: load the working register with A, load the counter with n, go to SHIFT.
  - n=0: result=A, carry_out=0, overflow=0, go straight to HOLD (latency 1).
- SHIFT:
  - Each cycle, shift or rotate the working register by 1 and decrement the counter.
  - carry_out tracks the bit just shifted out.
  - L_CROT/R_CROT rotate through the carry bit, seeded from carry_in, making a WIDTH+1-bit ring.
  - When the counter reaches 1, the final step registers result and flags and the FSM goes to HOLD. Total latency is n cycles from acceptance.
- HOLD:
  - out_valid=1; result and flags stable.
  - On out_ready, out_valid drops and the FSM returns to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Arithmetic:
  - Compute into WIDTH+1 bits. result = low WIDTH bits (wrap, no saturation).
  - ADD/CADD: carry_out = bit WIDTH.
  - SUB/BSUB: carry_out = borrow (unsigned A < B + borrow_in).
  - overflow = sign-rule V (operand signs equal and result sign differs; for SUB, the operand signs differ).
  - NEG of the most-negative value: result = same value, overflow=1.
  - INC of max-positive wraps to min-negative, overflow=1. DEC of min-negative wraps to max-positive, overflow=1.
- Shifts:
  - L_ARITH_SHIFT == L_LOG_SHIFT for the data path. L_ARITH_SHIFT sets overflow if the sign bit changed on any step.
  - R_ARITH_SHIFT replicates the sign bit.
- Undefined opcodes (20-31): result=0, flags 0, latency 1.
- in_valid while busy is ignored; the master must hold the request until in_ready.
- Reset asserted mid-SHIFT or mid-HOLD aborts the operation immediately and discards it.

Optional Feature:
- MUL_EN defined:
  - Opcode 20 = MUL, signed WIDTH x WIDTH via iterative shift-add (Booth radix-2) in state SHIFT, WIDTH cycles.
  - result = low WIDTH bits.
  - overflow=1 if the full 2*WIDTH product is not representable in WIDTH bits.
  - carry_out=0.
- MUL_EN undefined: opcode 20 is treated as undefined; no multiplier hardware.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=0 … OP_R_CROT=19, OP_MUL=20;
  - the FSM state enum (IDLE/SHIFT/HOLD);
  - the function is_shift_op().
- One sub-module, alu_shift_unit:
  - owns the working register, counter, carry ring and MUL accumulator;
  - exposes start/done to the main FSM.
- The combinational arithmetic and logic stays in alu_seq.

Test Plan (WIDTH=8):
- ADD A=100, B=50 → result=-106 (0x96), overflow=1, carry_out=0, negative=1; out_valid exactly 1 cycle after accept.
- SUB A=5, B=10 → result=-5 (0xFB), carry_out(borrow)=1, overflow=0. BSUB A=0, B=0, borrow_in=1 → 0xFF, borrow=1.
- R_ARITH_SHIFT A=0x80, n=3 → result=0xF0 after 3 cycles, busy high throughout, carry_out=0. L_CROT A=0x81, carry_in=0, n=1 → result=0x02, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → result stable, in_ready=0, second request accepted only after the out_ready handshake.
- Async reset asserted mid-SHIFT (n=6, after 2 cycles) → outputs at reset values immediately without a clock edge; the next op runs normally.
- INC 0x7F → 0x80, overflow=1. With MUL_EN: MUL 12 × -11 → 0x7C (-132 truncated), overflow=1, latency 8.
